// File: rtl/ram16k_arbiter.sv
// Two-port arbiter in front of the single-port 16K x 16 data RAM, with a
// clear engine that sweeps every word to CLEAR_VALUE after reset or on command.

module ram16k_arb_port #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt,
  input  logic              we,
  input  logic [DATA_W-1:0] ram_out,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);
  // rdata only moves on a read grant, so it holds across later writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= gnt;
      if (gnt && !we) rdata <= ram_out;
    end
  end
endmodule

module ram16k_arbiter #(
  parameter int                ADDR_W         = 14,
  parameter int                DATA_W         = 16,
  parameter int                PRIORITY_MODE  = 0,
  parameter int                CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clear_start,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_load,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out
);
  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  localparam logic [ADDR_W-1:0] CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] CNT_ONE = 1;

  // index 0 = port A, index 1 = port B
  logic [1:0]             req, we, gnt, ack;
  logic [1:0][ADDR_W-1:0] addr;
  logic [1:0][DATA_W-1:0] wdata, rdata;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              last_b_q, last_b_d;

  assign req   = {b_req, a_req};
  assign we    = {b_we, a_we};
  assign addr  = {b_addr, a_addr};
  assign wdata = {b_wdata, a_wdata};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    gnt      = '0;
    busy     = 1'b0;
    ram_addr = '0;
    ram_load = 1'b0;
    ram_in   = '0;
    case (state_q)
      ST_CLEAR: begin
        busy     = 1'b1;
        ram_load = 1'b1;
        ram_addr = cnt_q;
        ram_in   = CLEAR_VALUE;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_MAX) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        // on a tie, round-robin favours whichever port did not win last
        if (req == 2'b11)
          gnt = (PRIORITY_MODE != 0 || last_b_q) ? 2'b01 : 2'b10;
        else
          gnt = req;
        if (|gnt) begin
          ram_addr = addr[gnt[1]];
          ram_load = we[gnt[1]];
          ram_in   = wdata[gnt[1]];
          last_b_d = gnt[1];
        end
        if (clear_start) state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_b_q <= last_b_d;
    end
  end

  ram16k_arb_port #(.DATA_W(DATA_W)) u_port [1:0] (
    .clk     (clk),
    .rst_n   (rst_n),
    .gnt     (gnt),
    .we      (we),
    .ram_out (ram_out),
    .ack     (ack),
    .rdata   (rdata)
  );

  assign a_gnt   = gnt[0];
  assign b_gnt   = gnt[1];
  assign a_ack   = ack[0];
  assign b_ack   = ack[1];
  assign a_rdata = rdata[0];
  assign b_rdata = rdata[1];
endmodule

// File: tb/tb_ram16k_arbiter.sv
// Bench for ram16k_arbiter: a round-robin/zero-clear instance and a fixed-priority
// instance share one stimulus stream and are checked against a word-level model.

module tb_ram16k_arbiter;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int NW = 1 << AW;
  localparam logic [DW-1:0] CV0 = 16'h0000;
  localparam logic [DW-1:0] CV1 = 16'h5A5A;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          a_req, a_we, b_req, b_we, clear_start;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;

  logic [1:0]         a_gnt, a_ack, b_gnt, b_ack, busy, ram_load;
  logic [1:0][DW-1:0] a_rdata, b_rdata, ram_in, ram_out;
  logic [1:0][AW-1:0] ram_addr;

  ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0), .CLEAR_ON_RESET(1),
                   .CLEAR_VALUE(CV0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[0]), .a_ack(a_ack[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[0]), .b_ack(b_ack[0]), .b_rdata(b_rdata[0]),
    .clear_start(clear_start), .busy(busy[0]),
    .ram_addr(ram_addr[0]), .ram_load(ram_load[0]), .ram_in(ram_in[0]), .ram_out(ram_out[0])
  );

  ram16k_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1), .CLEAR_ON_RESET(1),
                   .CLEAR_VALUE(CV1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt[1]), .a_ack(a_ack[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt[1]), .b_ack(b_ack[1]), .b_rdata(b_rdata[1]),
    .clear_start(clear_start), .busy(busy[1]),
    .ram_addr(ram_addr[1]), .ram_load(ram_load[1]), .ram_in(ram_in[1]), .ram_out(ram_out[1])
  );

  // external RAMs: combinational read, write on the rising edge
  logic [DW-1:0] emem [2][NW];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (ram_load[k]) emem[k][ram_addr[k]] <= ram_in[k];
  assign ram_out[0] = emem[0][ram_addr[0]];
  assign ram_out[1] = emem[1][ram_addr[1]];

  // reference model
  logic [DW-1:0] cv [2] = '{CV0, CV1};
  logic [DW-1:0] m_mem [2][NW];
  int            m_clr [2];
  int            m_cidx [2];
  bit            m_lastb [2];
  bit            m_aack [2], m_back [2];
  logic [DW-1:0] m_ard [2], m_brd [2];
  bit            e_ag [2], e_bg [2];
  logic          o_ag [2], o_bg [2];
  int            busy_cnt [2];
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d: got %h, expected %h", tag, k, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_clr[k] = NW; m_cidx[k] = 0; m_lastb[k] = 1'b1;
      m_aack[k] = 1'b0; m_back[k] = 1'b0; m_ard[k] = '0; m_brd[k] = '0;
    end
  endtask

  task automatic chk_reset_vals();
    for (int k = 0; k < 2; k++) begin
      chk("rst_a_ack", k, 32'(a_ack[k]), 0);
      chk("rst_b_ack", k, 32'(b_ack[k]), 0);
      chk("rst_a_rdata", k, 32'(a_rdata[k]), 0);
      chk("rst_b_rdata", k, 32'(b_rdata[k]), 0);
      chk("rst_busy", k, 32'(busy[k]), 1);
      chk("rst_ram_addr", k, 32'(ram_addr[k]), 0);
      chk("rst_a_gnt", k, 32'(a_gnt[k]), 0);
    end
  endtask

  // one clock: check outputs at the falling edge, advance the model at the rising edge
  task automatic cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [AW-1:0] ea;
      logic          el;
      logic [DW-1:0] ei;
      e_ag[k] = 1'b0; e_bg[k] = 1'b0; ea = '0; el = 1'b0; ei = '0;
      if (m_clr[k] > 0) begin
        ea = AW'(m_cidx[k]); el = 1'b1; ei = cv[k];
      end else begin
        if (a_req && b_req) begin
          if (k == 1 || m_lastb[k]) e_ag[k] = 1'b1; else e_bg[k] = 1'b1;
        end else begin
          e_ag[k] = a_req; e_bg[k] = b_req;
        end
        if (e_ag[k]) begin ea = a_addr; el = a_we; ei = a_wdata; end
        else if (e_bg[k]) begin ea = b_addr; el = b_we; ei = b_wdata; end
      end
      o_ag[k] = a_gnt[k]; o_bg[k] = b_gnt[k];
      busy_cnt[k] += 32'(busy[k]);
      chk("busy", k, 32'(busy[k]), 32'(m_clr[k] > 0));
      chk("a_gnt", k, 32'(a_gnt[k]), 32'(e_ag[k]));
      chk("b_gnt", k, 32'(b_gnt[k]), 32'(e_bg[k]));
      chk("ram_addr", k, 32'(ram_addr[k]), 32'(ea));
      chk("ram_load", k, 32'(ram_load[k]), 32'(el));
      chk("ram_in", k, 32'(ram_in[k]), 32'(ei));
      chk("a_ack", k, 32'(a_ack[k]), 32'(m_aack[k]));
      chk("b_ack", k, 32'(b_ack[k]), 32'(m_back[k]));
      chk("a_rdata", k, 32'(a_rdata[k]), 32'(m_ard[k]));
      chk("b_rdata", k, 32'(b_rdata[k]), 32'(m_brd[k]));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (m_clr[k] > 0) begin
        m_mem[k][m_cidx[k]] = cv[k];
        m_cidx[k]++; m_clr[k]--;
        m_aack[k] = 1'b0; m_back[k] = 1'b0;
      end else begin
        m_aack[k] = e_ag[k]; m_back[k] = e_bg[k];
        if (e_ag[k]) begin
          if (a_we) m_mem[k][a_addr] = a_wdata; else m_ard[k] = m_mem[k][a_addr];
        end
        if (e_bg[k]) begin
          if (b_we) m_mem[k][b_addr] = b_wdata; else m_brd[k] = m_mem[k][b_addr];
        end
        if (e_ag[k] || e_bg[k]) m_lastb[k] = e_bg[k];
        if (clear_start) begin m_clr[k] = NW; m_cidx[k] = 0; end
      end
    end
    #1;
  endtask

  initial begin
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    clear_start = 0;
    model_reset();

    // power-on reset with both ports already asking for reads
    #1 rst_n = 1'b0;
    #1 chk_reset_vals();
    a_req = 1; a_addr = 5; b_req = 1; b_addr = 6;
    @(posedge clk); #1 rst_n = 1'b1;
    busy_cnt = '{0, 0};
    repeat (NW) cycle();
    for (int k = 0; k < 2; k++) chk("clear_len", k, busy_cnt[k], NW);

    // contention: alternate under round-robin, A always under fixed priority
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_a", 0, 32'(o_ag[0]), 32'(i % 2 == 0));
      chk("rr_b", 0, 32'(o_bg[0]), 32'(i % 2 == 1));
      chk("prio_a", 1, 32'(o_ag[1]), 1);
      chk("prio_b", 1, 32'(o_bg[1]), 0);
      if (i == 0)
        for (int k = 0; k < 2; k++) chk("cleared_rd5", k, 32'(a_rdata[k]), 32'(cv[k]));
    end
    a_req = 0; b_req = 0;
    cycle();

    // write then read-back of the same address on consecutive cycles
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 16'hBEEF;
    cycle();
    a_we = 0;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("raw_ack", k, 32'(a_ack[k]), 1);
      chk("raw_rdata", k, 32'(a_rdata[k]), 32'h0000BEEF);
      chk("raw_b_ack", k, 32'(b_ack[k]), 0);
    end
    a_req = 0;
    cycle();

    // read data holds through a following write's ack
    a_req = 1; a_we = 1; a_addr = 2; a_wdata = 16'h00AA;
    cycle();
    a_we = 0;
    cycle();
    a_we = 1; a_wdata = 16'h5555;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("hold_ack", k, 32'(a_ack[k]), 1);
      chk("hold_rdata", k, 32'(a_rdata[k]), 32'h000000AA);
    end
    a_req = 0; a_we = 0;
    cycle();

    // B write in the same cycle as clear_start still lands, then the clear wipes it
    b_req = 1; b_we = 1; b_addr = 7; b_wdata = 16'h1234; clear_start = 1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("cs_b_gnt", k, 32'(o_bg[k]), 1);
      chk("cs_write", k, 32'(emem[k][7]), 32'h00001234);
    end
    b_req = 0; b_we = 0; clear_start = 0;
    busy_cnt = '{0, 0};
    repeat (NW) cycle();
    for (int k = 0; k < 2; k++) chk("cmd_clear_len", k, busy_cnt[k], NW);
    a_req = 1; a_we = 0; a_addr = 7;
    cycle();
    for (int k = 0; k < 2; k++) chk("cleared_rd7", k, 32'(a_rdata[k]), 32'(cv[k]));
    a_req = 0;
    cycle();

    // reset pulse in the middle of a clear restarts it from address 0
    clear_start = 1;
    cycle();
    clear_start = 0;
    repeat (9) cycle();
    for (int k = 0; k < 2; k++) chk("mid_clear_addr", k, 32'(ram_addr[k]), 9);
    rst_n = 1'b0;
    #1 chk_reset_vals();
    model_reset();
    #1 rst_n = 1'b1;
    busy_cnt = '{0, 0};
    repeat (NW) cycle();
    for (int k = 0; k < 2; k++) chk("restart_len", k, busy_cnt[k], NW);

    // random traffic
    repeat (400) begin
      a_req = ($urandom_range(0, 3) != 0); a_we = 1'($urandom);
      a_addr = AW'($urandom); a_wdata = DW'($urandom);
      b_req = ($urandom_range(0, 3) != 0); b_we = 1'($urandom);
      b_addr = AW'($urandom); b_wdata = DW'($urandom);
      clear_start = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
